// File: rtl/lfsr_crypto_engine.sv
// LFSR stream cipher for 7-bit ASCII bytes: encrypts with a chosen tap pattern and seed,
// decrypts by recovering pattern and seed from a known run of leading 0x20 pad bytes.
module lfsr_crypto_engine #(
  parameter int LFSR_W   = 7,
  parameter int MSG_LEN  = 64,
  parameter int NUM_PTRN = 9,
  parameter int PRE_MIN  = 10
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Mode,
  input  logic [LFSR_W-1:0]          SeedIn,
  input  logic [3:0]                 PtrnSel,
  input  logic [NUM_PTRN*LFSR_W-1:0] Ptrns,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [7:0]                 InData,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [7:0]                 OutData,
  output logic                       Ack,
  output logic                       NoMatch,
  output logic [3:0]                 PtrnFound,
  output logic [LFSR_W-1:0]          SeedFound,
  output logic [6:0]                 ParErrs
);

  localparam int CNT_W = $clog2(MSG_LEN + 1);

  typedef enum logic [1:0] {IDLE, TRAIN, RUN, DONE} state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] taps);
    return {s[LFSR_W-2:0], ^(s & taps)};
  endfunction

  function automatic logic parity7(input logic [6:0] v);
    return ^v;
  endfunction

  state_t              r_fsm;
  state_t              w_fsm_nxt;
  logic                r_mode;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [LFSR_W-1:0]   r_taps;
  logic [LFSR_W-1:0]   r_s0;
  logic [CNT_W-1:0]    r_cnt;
  logic [LFSR_W-1:0]   r_cand [NUM_PTRN];
  logic [NUM_PTRN-1:0] r_alive;
  logic                r_out_valid;
  logic [7:0]          r_out_data;
  logic                r_nomatch;
  logic [3:0]          r_ptrn_found;
  logic [LFSR_W-1:0]   r_seed_found;
  logic [6:0]          r_par;

  logic                w_fire;
  logic                w_ack;
  logic                w_start;
  logic                w_last_train;
  logic                w_last_msg;
  logic                w_par_bad;
  logic [6:0]          w_c;
  logic [LFSR_W-1:0]   w_pad_s;
  logic [7:0]          w_out_byte;
  logic [3:0]          w_psel;
  logic [LFSR_W-1:0]   w_seed;
  logic [LFSR_W-1:0]   w_enc_taps;
  logic [LFSR_W-1:0]   w_adv [NUM_PTRN];
  logic [NUM_PTRN-1:0] w_match;
  logic [NUM_PTRN-1:0] w_alive_nxt;
  logic                w_any;
  logic [3:0]          w_sel;
  logic [LFSR_W-1:0]   w_sel_taps;
  logic [LFSR_W-1:0]   w_sel_adv;

  assign InReady   = ((r_fsm == TRAIN) || (r_fsm == RUN)) && (!r_out_valid || OutReady);
  assign w_fire    = InValid && InReady;
  assign w_ack     = (r_fsm == DONE) && !r_out_valid;
  assign w_start   = Start && ((r_fsm == IDLE) || w_ack);
  assign OutValid  = r_out_valid;
  assign OutData   = r_out_data;
  assign Ack       = w_ack;
  assign NoMatch   = r_nomatch;
  assign PtrnFound = r_ptrn_found;
  assign SeedFound = r_seed_found;
  assign ParErrs   = r_par;

  assign w_last_train = (r_cnt == CNT_W'(PRE_MIN - 1));
  assign w_last_msg   = (r_cnt == CNT_W'(MSG_LEN - 1));
  assign w_par_bad    = InData[7] != parity7(InData[6:0]);
  assign w_c          = InData[6:0] ^ 7'(r_lfsr);
  // During training the pad byte is known, so the keystream state is read straight off the input.
  assign w_pad_s      = LFSR_W'(InData[6:0] ^ 7'h20);
  assign w_psel       = ({28'd0, PtrnSel} >= 32'(NUM_PTRN)) ? 4'd0 : PtrnSel;
  assign w_seed       = (SeedIn == '0) ? LFSR_W'(1) : SeedIn;
  assign w_alive_nxt  = r_alive & w_match;

  always_comb begin
    if (r_fsm == TRAIN)  w_out_byte = 8'h20;
    else if (r_mode)     w_out_byte = {1'b0, w_c};
    else                 w_out_byte = {parity7(w_c), w_c};
  end

  always_comb begin
    w_enc_taps = Ptrns[LFSR_W-1:0];
    for (int k = 0; k < NUM_PTRN; k++)
      if (w_psel == 4'(k)) w_enc_taps = Ptrns[k*LFSR_W +: LFSR_W];
  end

  always_comb begin
    w_match = '0;
    for (int k = 0; k < NUM_PTRN; k++) begin
      w_adv[k]   = lfsr_step(r_cand[k], Ptrns[k*LFSR_W +: LFSR_W]);
      w_match[k] = (w_adv[k] == w_pad_s);
    end
  end

  // Descending scan so the lowest-index survivor wins.
  always_comb begin
    w_any      = 1'b0;
    w_sel      = 4'd0;
    w_sel_taps = Ptrns[LFSR_W-1:0];
    w_sel_adv  = w_adv[0];
    for (int k = NUM_PTRN - 1; k >= 0; k--) begin
      if (w_alive_nxt[k]) begin
        w_any      = 1'b1;
        w_sel      = 4'(k);
        w_sel_taps = Ptrns[k*LFSR_W +: LFSR_W];
        w_sel_adv  = w_adv[k];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_fsm <= IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      IDLE:  if (w_start) w_fsm_nxt = Mode ? TRAIN : RUN;
      TRAIN: if (w_fire && w_last_train) w_fsm_nxt = w_any ? RUN : DONE;
      RUN:   if (w_fire && w_last_msg) w_fsm_nxt = DONE;
      DONE:  if (w_start) w_fsm_nxt = Mode ? TRAIN : RUN;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mode       <= 1'b0;
      r_lfsr       <= '0;
      r_taps       <= '0;
      r_s0         <= '0;
      r_cnt        <= '0;
      r_alive      <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'h00;
      r_nomatch    <= 1'b0;
      r_ptrn_found <= 4'd0;
      r_seed_found <= '0;
      r_par        <= 7'd0;
      for (int k = 0; k < NUM_PTRN; k++) r_cand[k] <= '0;
    end else begin
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_out_byte;
      end else if (OutReady) begin
        r_out_valid <= 1'b0;
      end

      if (w_start) begin
        r_mode    <= Mode;
        r_lfsr    <= w_seed;
        r_taps    <= w_enc_taps;
        r_cnt     <= '0;
        r_par     <= 7'd0;
        r_nomatch <= 1'b0;
      end else if (w_fire) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_mode && w_par_bad && (r_par != 7'h7F)) r_par <= r_par + 1'b1;
        if (r_fsm == TRAIN) begin
          if (r_cnt == '0) begin
            r_s0    <= w_pad_s;
            r_alive <= '1;
            for (int k = 0; k < NUM_PTRN; k++) r_cand[k] <= w_pad_s;
          end else begin
            r_alive <= w_alive_nxt;
            for (int k = 0; k < NUM_PTRN; k++) r_cand[k] <= w_adv[k];
            if (w_last_train) begin
              if (w_any) begin
                r_ptrn_found <= w_sel;
                r_seed_found <= r_s0;
                r_taps       <= w_sel_taps;
                r_lfsr       <= lfsr_step(w_sel_adv, w_sel_taps);
              end else begin
                r_nomatch <= 1'b1;
              end
            end
          end
        end else begin
          r_lfsr <= lfsr_step(r_lfsr, r_taps);
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_crypto_engine.sv
// Scoreboard bench for lfsr_crypto_engine: directed encrypt/decrypt messages, backpressure,
// parity errors, failed training and mid-run reset.
module tb_lfsr_crypto_engine;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Mode = 1'b0;
  logic [6:0]  SeedIn = 7'd0;
  logic [3:0]  PtrnSel = 4'd0;
  logic [62:0] Ptrns = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [7:0]  InData = 8'h00;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [7:0]  OutData;
  logic        Ack;
  logic        NoMatch;
  logic [3:0]  PtrnFound;
  logic [6:0]  SeedFound;
  logic [6:0]  ParErrs;

  lfsr_crypto_engine dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .SeedIn(SeedIn),
    .PtrnSel(PtrnSel), .Ptrns(Ptrns), .InValid(InValid), .InReady(InReady),
    .InData(InData), .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .Ack(Ack), .NoMatch(NoMatch), .PtrnFound(PtrnFound), .SeedFound(SeedFound),
    .ParErrs(ParErrs)
  );

  always #5 Clk = ~Clk;

  // Entry 0 is the rightmost field. Entries 0-3 and 5-8 all disagree with 0x60 on the
  // first step from seed 0x35, so only entry 4 can survive training in table B.
  localparam logic [62:0] TBL_A = {7'h05, 7'h11, 7'h42, 7'h48, 7'h60, 7'h05, 7'h11, 7'h42, 7'h60};
  localparam logic [62:0] TBL_B = {7'h05, 7'h11, 7'h42, 7'h48, 7'h60, 7'h05, 7'h11, 7'h42, 7'h48};

  int n_checks = 0;
  int n_fail   = 0;
  int out_cnt  = 0;
  bit rnd_rdy  = 1'b0;
  bit hold_pend = 1'b0;
  logic [7:0] hold_data;
  logic [7:0] exp_q [$];
  logic [7:0] pt  [64];
  logic [7:0] ct  [64];
  logic [7:0] din [64];
  logic [7:0] dexp[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] nx(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  function automatic void build_ct(input logic [6:0] seed, input logic [6:0] taps);
    logic [6:0] s;
    logic [6:0] x;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      x = pt[i][6:0] ^ s;
      ct[i] = {^x, x};
      s = nx(s, taps);
    end
  endfunction

  // Output monitor: pops the scoreboard on every accepted byte and checks hold stability.
  always @(negedge Clk) begin
    if (Reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", {31'd0, OutValid}, 32'd1);
        chk("hold_data", {24'd0, OutData}, {24'd0, hold_data});
      end
      if (OutValid && OutReady) begin
        out_cnt++;
        if (exp_q.size() == 0) chk("extra_output", {24'd0, OutData}, 32'hFFFF_FFFF);
        else chk("out_byte", {24'd0, OutData}, {24'd0, exp_q.pop_front()});
      end
      hold_pend = OutValid && !OutReady;
      hold_data = OutData;
    end
  end

  initial forever begin
    @(posedge Clk); #1;
    OutReady = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input bit m, input logic [3:0] sel, input logic [6:0] seed,
                          input logic [62:0] tbl);
    Mode = m; PtrnSel = sel; SeedIn = seed; Ptrns = tbl; Start = 1'b1; out_cnt = 0;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] e);
    int t = 0;
    InData = b; InValid = 1'b1;
    exp_q.push_back(e);
    forever begin
      @(negedge Clk);
      if (InReady) break;
      t++;
      if (t > 1000) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  task automatic send_msg(input int n, input bit poke);
    for (int i = 0; i < n; i++) begin
      if (poke && i == 5) begin Start = 1'b1; Mode = ~Mode; SeedIn = 7'h7F; end
      send_byte(din[i], dexp[i]);
      if (poke && i == 5) begin Start = 1'b0; Mode = ~Mode; end
    end
  endtask

  task automatic wait_ack(input string name);
    int t = 0;
    while (!Ack && t < 2000) begin @(negedge Clk); t++; end
    chk(name, {31'd0, Ack}, 32'd1);
    chk({name, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic load_decrypt(input bit par_flip, input bit corrupt3);
    for (int i = 0; i < 64; i++) begin
      din[i]  = ct[i];
      dexp[i] = (i < 10) ? 8'h20 : pt[i];
    end
    if (par_flip) begin din[20] = din[20] ^ 8'h80; din[30] = din[30] ^ 8'h80; end
    if (corrupt3) din[3] = din[3] ^ 8'h01;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_inready", {31'd0, InReady}, 32'd0);
    chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("rst_ack", {31'd0, Ack}, 32'd0);
    chk("rst_nomatch", {31'd0, NoMatch}, 32'd0);
    chk("rst_outdata", {24'd0, OutData}, 32'd0);
    chk("rst_parerrs", {25'd0, ParErrs}, 32'd0);
    chk("rst_ptrnfound", {28'd0, PtrnFound}, 32'd0);
    chk("rst_seedfound", {25'd0, SeedFound}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Known vector: pattern 0x60, seed 1, six spaces then 'A'; tail bytes follow the model.
    for (int i = 0; i < 64; i++) pt[i] = (i < 6) ? 8'h20 : (i == 6) ? 8'h41 : 8'h20 + 8'((i * 7) % 95);
    build_ct(7'h01, 7'h60);
    for (int i = 0; i < 64; i++) begin din[i] = pt[i]; dexp[i] = ct[i]; end
    dexp[0] = 8'h21; dexp[1] = 8'h22; dexp[2] = 8'h24; dexp[3] = 8'h28;
    dexp[4] = 8'h30; dexp[5] = 8'h00; dexp[6] = 8'h00;
    do_start(1'b0, 4'd0, 7'h01, TBL_A);
    send_msg(64, 1'b0);
    wait_ack("enc_known_ack");
    chk("enc_known_count", out_cnt, 32'd64);

    // Out-of-range pattern index falls back to 0 and zero seed becomes 1: same stream.
    do_start(1'b0, 4'd12, 7'h00, TBL_A);
    send_msg(64, 1'b0);
    wait_ack("enc_fallback_ack");

    // Round trip plaintext: 12 pad bytes then printable ASCII.
    for (int i = 0; i < 64; i++) pt[i] = (i < 12) ? 8'h20 : 8'h20 + 8'((i * 7) % 95);
    build_ct(7'h35, 7'h60);
    for (int i = 0; i < 64; i++) begin din[i] = pt[i]; dexp[i] = ct[i]; end
    do_start(1'b0, 4'd4, 7'h35, TBL_B);
    send_msg(64, 1'b1);
    wait_ack("enc_rt_ack");
    chk("enc_rt_count", out_cnt, 32'd64);

    load_decrypt(1'b0, 1'b0);
    do_start(1'b1, 4'd0, 7'h00, TBL_B);
    send_msg(64, 1'b0);
    wait_ack("dec_rt_ack");
    chk("dec_rt_ptrn", {28'd0, PtrnFound}, 32'd4);
    chk("dec_rt_seed", {25'd0, SeedFound}, 32'h35);
    chk("dec_rt_parerrs", {25'd0, ParErrs}, 32'd0);
    chk("dec_rt_nomatch", {31'd0, NoMatch}, 32'd0);
    chk("dec_rt_count", out_cnt, 32'd64);

    // Parity errors on bytes 20 and 30, with random backpressure on the output.
    load_decrypt(1'b1, 1'b0);
    rnd_rdy = 1'b1;
    do_start(1'b1, 4'd0, 7'h00, TBL_B);
    send_msg(64, 1'b0);
    wait_ack("dec_par_ack");
    chk("dec_par_parerrs", {25'd0, ParErrs}, 32'd2);
    chk("dec_par_count", out_cnt, 32'd64);

    // Reset in the middle of a run, then a fresh run from byte 0.
    do_start(1'b1, 4'd0, 7'h00, TBL_B);
    send_msg(30, 1'b0);
    Reset = 1'b1;
    exp_q.delete();
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("post_rst_outvalid", {31'd0, OutValid}, 32'd0);
    end
    chk("post_rst_inready", {31'd0, InReady}, 32'd0);
    chk("post_rst_parerrs", {25'd0, ParErrs}, 32'd0);
    chk("post_rst_ack", {31'd0, Ack}, 32'd0);
    @(posedge Clk); #1;
    do_start(1'b1, 4'd0, 7'h00, TBL_B);
    send_msg(64, 1'b0);
    wait_ack("dec_rerun_ack");
    chk("dec_rerun_parerrs", {25'd0, ParErrs}, 32'd2);
    chk("dec_rerun_ptrn", {28'd0, PtrnFound}, 32'd4);
    chk("dec_rerun_count", out_cnt, 32'd64);
    rnd_rdy = 1'b0;
    @(posedge Clk); #1;

    // Corrupted training byte: no pattern survives, engine stops after the pad window.
    load_decrypt(1'b0, 1'b1);
    do_start(1'b1, 4'd0, 7'h00, TBL_B);
    send_msg(10, 1'b0);
    wait_ack("nomatch_ack");
    chk("nomatch_flag", {31'd0, NoMatch}, 32'd1);
    chk("nomatch_inready", {31'd0, InReady}, 32'd0);
    chk("nomatch_count", out_cnt, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
